// File: rtl/approx_eval_pkg.sv
// Shared types and width helpers for the approximate-multiplier sweep controller.
package approx_eval_pkg;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} sweep_state_t;

  function automatic int res_w(input int w);
    return 2 * w;
  endfunction

  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int sum_w(input int w);
    return 4 * w;
  endfunction

endpackage

// File: rtl/approx_err_accum.sv
// Error-metric accumulator: compares a tagged MUT result with the exact product.
// Optional signed bias accumulator under APPROX_SWEEP_BIAS_EN.
module approx_err_accum
  import approx_eval_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic [W-1:0]             a,
  input  logic [W-1:0]             b,
  input  logic [res_w(W)-1:0]      approx,
`ifdef APPROX_SWEEP_BIAS_EN
  output logic signed [sum_w(W):0] bias_sum,
`endif
  output logic [cnt_w(W)-1:0]      err_count,
  output logic [sum_w(W)-1:0]      sum_ed,
  output logic [res_w(W)-1:0]      max_ed
);
  localparam int RES_W = res_w(W);
  localparam int CNT_W = cnt_w(W);
  localparam int SUM_W = sum_w(W);

  logic [RES_W-1:0] exact, ed;

  assign exact = RES_W'(a) * RES_W'(b);
  assign ed    = (approx >= exact) ? approx - exact : exact - approx;

`ifdef APPROX_SWEEP_BIAS_EN
  logic signed [SUM_W:0] diff;
  assign diff = $signed({{(SUM_W+1-RES_W){1'b0}}, approx})
              - $signed({{(SUM_W+1-RES_W){1'b0}}, exact});

  always_ff @(posedge clk or posedge rst)
    if (rst)      bias_sum <= '0;
    else if (clr) bias_sum <= '0;
    else if (en)  bias_sum <= bias_sum + diff;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
    end else if (clr) begin
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
    end else if (en) begin
      err_count <= err_count + CNT_W'(ed != '0);
      sum_ed    <= sum_ed + SUM_W'(ed);
      if (ed > max_ed) max_ed <= ed;
    end

endmodule

// File: rtl/approx_mult_sweep_ctrl.sv
// Sweep controller: walks every (A,B) pair through a MUT and accumulates error metrics.
// Optional bias_sum output under APPROX_SWEEP_BIAS_EN.
module approx_mult_sweep_ctrl
  import approx_eval_pkg::*;
#(
  parameter int W       = 4,
  parameter int MUL_LAT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  output logic [W-1:0]             op_a,
  output logic [W-1:0]             op_b,
  input  logic [res_w(W)-1:0]      approx_result,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
`ifdef APPROX_SWEEP_BIAS_EN
  output logic signed [sum_w(W):0] bias_sum,
`endif
  output logic [cnt_w(W)-1:0]      err_count,
  output logic [sum_w(W)-1:0]      sum_ed,
  output logic [res_w(W)-1:0]      max_ed,
  output logic [res_w(W)-1:0]      mean_ed
);
  localparam int RES_W   = res_w(W);
  localparam int SUM_W   = sum_w(W);
  localparam int DRAIN_W = $clog2(MUL_LAT + 2);
  localparam logic [RES_W-1:0] LAST = '1;

  sweep_state_t                  state;
  logic [MUL_LAT:0]              vld_pipe;
  logic [MUL_LAT:0][RES_W-1:0]   opnd_pipe;  // stage 0 is the operand register itself
  logic [DRAIN_W-1:0]            drain_cnt;
  logic                          acc_clr, acc_en;

  assign op_a    = opnd_pipe[0][RES_W-1:W];
  assign op_b    = opnd_pipe[0][W-1:0];
  assign mean_ed = sum_ed[SUM_W-1:RES_W];
  assign acc_clr = (state == IDLE) && start;
  // An abort edge must not fold in the sample arriving on that same edge.
  assign acc_en  = vld_pipe[MUL_LAT] && !abort;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      vld_pipe  <= '0;
      opnd_pipe <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      for (int i = 1; i <= MUL_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        opnd_pipe[i] <= opnd_pipe[i-1];
      end
      case (state)
        IDLE:
          if (start) begin
            state        <= SWEEP;
            busy         <= 1'b1;
            aborted      <= 1'b0;
            vld_pipe[0]  <= 1'b1;
            opnd_pipe[0] <= '0;
          end
        SWEEP, DRAIN:
          if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            aborted  <= 1'b1;
            vld_pipe <= '0;
          end else if (state == SWEEP) begin
            // SWEEP stays one cycle past the last issue so the final sample lands first.
            if (vld_pipe[0]) begin
              if (opnd_pipe[0] == LAST) vld_pipe[0]  <= 1'b0;
              else                      opnd_pipe[0] <= opnd_pipe[0] + 1'b1;
            end else if (MUL_LAT == 0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_W'(MUL_LAT - 1);
            end
          end else if (drain_cnt == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end

  approx_err_accum #(.W(W)) u_accum (
    .clk       (clk),
    .rst       (rst),
    .clr       (acc_clr),
    .en        (acc_en),
    .a         (opnd_pipe[MUL_LAT][RES_W-1:W]),
    .b         (opnd_pipe[MUL_LAT][W-1:0]),
    .approx    (approx_result),
`ifdef APPROX_SWEEP_BIAS_EN
    .bias_sum  (bias_sum),
`endif
    .err_count (err_count),
    .sum_ed    (sum_ed),
    .max_ed    (max_ed)
  );

endmodule

// File: tb/tb_approx_mult_sweep_ctrl.sv
// Bench: two controllers (MUL_LAT 0 and 2) share stimulus; a table-driven MUT stub feeds both.
module tb_approx_mult_sweep_ctrl;
  localparam int W = 4;
  localparam int N = 256;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] lut [N];

  logic [W-1:0] op_a0, op_b0, op_a1, op_b1;
  logic [7:0]   approx0, approx1, s1, s2;
  logic         busy0, done0, ab0, busy1, done1, ab1;
  logic [8:0]   err0, err1;
  logic [15:0]  sum0, sum1;
  logic [7:0]   max0, max1, mean0, mean1;
`ifdef APPROX_SWEEP_BIAS_EN
  logic signed [16:0] bias0, bias1;
`endif

  assign approx0 = lut[{op_a0, op_b0}];
  always @(posedge clk) begin
    s1 <= lut[{op_a1, op_b1}];
    s2 <= s1;
  end
  assign approx1 = s2;

  approx_mult_sweep_ctrl #(.W(W), .MUL_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .op_a(op_a0), .op_b(op_b0), .approx_result(approx0),
    .busy(busy0), .done(done0), .aborted(ab0),
`ifdef APPROX_SWEEP_BIAS_EN
    .bias_sum(bias0),
`endif
    .err_count(err0), .sum_ed(sum0), .max_ed(max0), .mean_ed(mean0));

  approx_mult_sweep_ctrl #(.W(W), .MUL_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .op_a(op_a1), .op_b(op_b1), .approx_result(approx1),
    .busy(busy1), .done(done1), .aborted(ab1),
`ifdef APPROX_SWEEP_BIAS_EN
    .bias_sum(bias1),
`endif
    .err_count(err1), .sum_ed(sum1), .max_ed(max1), .mean_ed(mean1));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // 0 exact, 1 zero, 2 LSB-cleared, 3 exact with random corruption
  task automatic fill_lut(input int mode);
    for (int i = 0; i < N; i++) begin
      int ex;
      ex = (i / 16) * (i % 16);
      case (mode)
        0: lut[i] = 8'(ex);
        1: lut[i] = 8'd0;
        2: lut[i] = 8'(ex & 'hFE);
        default: lut[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'(ex);
      endcase
    end
  endtask

  // Metrics over the first np pairs of the sweep order.
  task automatic model(input int np, output longint e, output longint s,
                       output longint m, output longint bsum);
    e = 0; s = 0; m = 0; bsum = 0;
    for (int n = 0; n < np; n++) begin
      longint d, ad;
      d  = longint'(lut[n]) - (n / 16) * (n % 16);
      ad = (d < 0) ? -d : d;
      if (ad != 0) e++;
      s += ad;
      if (ad > m) m = ad;
      bsum += d;
    end
  endtask

  task automatic check_metrics(input string tag, input int np0, input int np1);
    longint e, s, m, bs;
    model(np0, e, s, m, bs);
    chk({tag, ".err0"}, err0, e);
    chk({tag, ".sum0"}, sum0, s);
    chk({tag, ".max0"}, max0, m);
    chk({tag, ".mean0"}, mean0, s / N);
`ifdef APPROX_SWEEP_BIAS_EN
    chk({tag, ".bias0"}, longint'(bias0), bs);
`endif
    model(np1, e, s, m, bs);
    chk({tag, ".err1"}, err1, e);
    chk({tag, ".sum1"}, sum1, s);
    chk({tag, ".max1"}, max1, m);
`ifdef APPROX_SWEEP_BIAS_EN
    chk({tag, ".bias1"}, longint'(bias1), bs);
`endif
  endtask

  task automatic launch(input bit with_abort, output int k0);
    start = 1'b1;
    abort = with_abort;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    k0 = cyc;
  endtask

  task automatic sweep(input string tag, input bit restarts, input bit with_abort);
    int k0, d0, d1, nd0, nd1;
    launch(with_abort, k0);
    chk({tag, ".busy_start"}, busy0, 1);
    chk({tag, ".ab_clr"}, ab0, 0);
    d0 = -1; d1 = -1; nd0 = 0; nd1 = 0;
    for (int i = 0; i < 300; i++) begin
      if (done0) begin nd0++; if (d0 < 0) d0 = cyc - k0; end
      if (done1) begin nd1++; if (d1 < 0) d1 = cyc - k0; end
      start = restarts && (cyc - k0 == 10 || cyc - k0 == 100);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, ".done0_lat"}, d0, 257);
    chk({tag, ".done1_lat"}, d1, 259);
    chk({tag, ".done0_cnt"}, nd0, 1);
    chk({tag, ".done1_cnt"}, nd1, 1);
    chk({tag, ".busy_end"}, {busy0, busy1}, 0);
    check_metrics(tag, N, N);
  endtask

  initial begin
    int k0, nd;
    fill_lut(0);
    repeat (3) @(negedge clk);
    chk("rst.busy", {busy0, busy1}, 0);
    chk("rst.done", {done0, done1}, 0);
    chk("rst.aborted", {ab0, ab1}, 0);
    chk("rst.ops", {op_a0, op_b0, op_a1, op_b1}, 0);
    chk("rst.metrics", {err0, sum0, max0, err1, sum1, max1}, 0);
    rst = 1'b0;
    @(negedge clk);

    sweep("exact", 0, 0);
    chk("exact.sum0_k", sum0, 0);

    fill_lut(1);
    sweep("zero", 0, 0);
    chk("zero.err0_k", err0, 225);
    chk("zero.sum0_k", sum0, 14400);
    chk("zero.max0_k", max0, 225);
    chk("zero.mean0_k", mean0, 56);

    fill_lut(2);
    sweep("trunc", 0, 0);
    chk("trunc.err1_k", err1, 64);
    chk("trunc.sum1_k", sum1, 64);
    chk("trunc.max1_k", max1, 1);

    fill_lut(3);
    sweep("restart", 1, 0);

    // abort lands at edge k+51: pairs 0..49 (lat 0) and 0..47 (lat 2) are counted
    fill_lut(3);
    launch(0, k0);
    while (cyc - k0 < 50) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.busy", {busy0, busy1}, 0);
    chk("abort.aborted", {ab0, ab1}, 2'b11);
    chk("abort.op0_hold", {op_a0, op_b0}, 50);
    check_metrics("abort", 50, 48);
    nd = 0;
    for (int i = 0; i < 300; i++) begin
      if (done0 || done1) nd++;
      @(negedge clk);
    end
    chk("abort.no_done", nd, 0);
    chk("abort.still_ab", ab0, 1);

    sweep("start_abort", 0, 1);

    fill_lut(3);
    launch(0, k0);
    while (cyc - k0 < 30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.busy", {busy0, busy1}, 0);
    chk("arst.ops", {op_a0, op_b0, op_a1, op_b1}, 0);
    chk("arst.metrics", {err0, sum0, max0, err1, sum1, max1}, 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 300; i++) begin
      if (done0 || done1) nd++;
      @(negedge clk);
    end
    chk("arst.no_done", nd, 0);

    fill_lut(3);
    sweep("post_rst", 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/approx_mult_sweep_ctrl.md
Name: approx_mult_sweep_ctrl

Overview:
Hardware sweep controller for characterising one approximate multiplier under test (MUT). Drives every operand pair (A,B) into the MUT, one pair per clock. Compares each MUT result against the exact product and accumulates error metrics: error count, sum of error distance, and maximum error distance. Sits beside the MUT in the characterisation wrapper, so per-design error figures come from silicon/FPGA rather than simulation only.

Parameters:
W, 4, operand width in bits; the MUT result is 2W bits.
MUL_LAT, 0, MUT latency in clocks from operand registers to valid result (0 = combinational MUT).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request a new sweep; sampled only in IDLE.
abort  input  1  terminate a running sweep.
op_a  output  W  operand A to MUT, registered.
op_b  output  W  operand B to MUT, registered.
approx_result  input  2W  MUT product.
busy  output  1  high in SWEEP and DRAIN.
done  output  1  one-cycle pulse when the sweep completes normally.
aborted  output  1  sticky; set by abort, cleared by the next accepted start.
err_count  output  2W+1  number of pairs where approx != exact.
sum_ed  output  4W  sum of |approx - exact| over all pairs.
max_ed  output  2W  maximum |approx - exact|.
mean_ed  output  2W  sum_ed[4W-1:2W], the integer mean over 2^(2W) pairs.

Behaviour:
- Reset: state=IDLE. op_a, op_b, busy, done, aborted, err_count, sum_ed and max_ed all 0. Delay line cleared.
- States: IDLE -> SWEEP on start. SWEEP -> DRAIN after the last pair is issued. DRAIN -> DONE after MUL_LAT cycles; with MUL_LAT=0, DRAIN is skipped. DONE -> IDLE after 1 cycle. abort in SWEEP or DRAIN -> IDLE.
- Start accepted at edge k: accumulators and aborted clear; cnt=0; busy=1.
- Pair n (0..2^(2W)-1) is presented after edge k+n. op_a=cnt[2W-1:W], op_b=cnt[W-1:0].
- A MUL_LAT-deep valid+operand delay line tags each pair. The result for pair n is sampled at edge k+n+1+MUL_LAT.
- The exact product is computed internally from the delayed operands (unsigned, 2W bits).
- ed = |approx - exact|, 2W bits. err_count += (ed != 0). sum_ed += ed, with no overflow possible (max 2^(2W) * (2^(2W)-1)). max_ed = max(max_ed, ed).
- Pairs with exact = 0 are included in all metrics.
- After the final sample edge (k+2^(2W)+MUL_LAT), done=1 and busy=0 for exactly one cycle. With W=4 and MUL_LAT=0, done is high after edge k+257.
- Results hold until the next accepted start.
- start while busy, or in DONE, is ignored.
- start and abort together in IDLE: start is accepted and abort is ignored.
- abort in SWEEP/DRAIN: takes effect at the next edge. The delay line is flushed, results freeze at partial values, aborted=1, done never pulses, op_a/op_b hold their last values.
- Async rst mid-sweep: immediate return to reset values; no done.

Optional Feature:
Macro APPROX_SWEEP_BIAS_EN.
- Defined: adds output bias_sum (signed, 4W+1 bits) = Σ(approx - exact). It clears with the other accumulators and freezes on abort.
- Not defined: the port and its logic are absent; all other behaviour is unchanged.

Decomposition:
- Shared package approx_eval_pkg: state enum (IDLE, SWEEP, DRAIN, DONE) and width helper constants (RES_W=2W, CNT_W=2W+1, SUM_W=4W).
- One natural sub-module: approx_err_accum. It takes the delayed valid, operands and approx result, and holds err_count, sum_ed, max_ed (and bias_sum). It has a clear input.
- The top level keeps the FSM, operand counter and delay line.

Test Plan:
- Exact stub (approx = op_a*op_b), W=4, MUL_LAT=0, start pulse -> done after edge k+257; err_count=0, sum_ed=0, max_ed=0, mean_ed=0.
- Zero stub (approx=0) -> err_count=225, sum_ed=14400, max_ed=225, mean_ed=56; with APPROX_SWEEP_BIAS_EN, bias_sum=-14400.
- LSB-truncating stub (exact & ~1), MUL_LAT=2 with a 2-stage registered stub -> err_count=64, sum_ed=64, max_ed=1; done after edge k+259.
- start re-pulsed at cycles 10 and 100 of a sweep -> ignored; a single done with the same results as the undisturbed run.
- abort at cycle 50 -> IDLE next edge, aborted=1, no done, busy=0. A subsequent start clears aborted and gives full results.
- rst asserted mid-sweep (async, between edges) -> all outputs 0 immediately. The next start completes normally.
